// File: rtl/note_input_conditioner.sv
// Push-button front end: synchronise, debounce, reject chords, and hand one
// one-hot note per key release to the response checker through a valid/ack slot.
module note_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_in,
  input  logic       enable,
  input  logic       note_ack,
  output logic [3:0] note_out,
  output logic       note_valid,
  output logic [3:0] keys_level,
  output logic       chord_error,
  output logic       overrun
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, RELEASE} state_t;

  logic [3:0] pressed;
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  state_t     state;
  logic [3:0] cand;
  logic       level_onehot;
  logic       slot_free;

  assign pressed = ACTIVE_LOW ? ~key_in : key_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 4'b0000;
      sync2_reg <= 4'b0000;
    end else begin
      sync1_reg <= pressed;
      sync2_reg <= sync1_reg;
    end
  end

  // A level only flips after DEBOUNCE_CYCLES unbroken cycles of disagreement.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
      logic [CW-1:0] cnt;
      logic          level;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt   <= '0;
          level <= 1'b0;
        end else if (sync2_reg[gi] == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt   <= '0;
          level <= ~level;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign keys_level[gi] = level;
    end
  endgenerate

  assign level_onehot = (keys_level != 4'b0000) &&
                        ((keys_level & (keys_level - 4'd1)) == 4'b0000);
  assign slot_free    = !note_valid || note_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cand        <= 4'b0000;
      note_out    <= 4'b0000;
      note_valid  <= 1'b0;
      chord_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      chord_error <= 1'b0;
      overrun     <= 1'b0;
      // An emit in the same cycle below takes precedence over this clear.
      if (note_ack && note_valid)
        note_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (keys_level != 4'b0000) begin
            if (!enable) begin
              state <= RELEASE;
            end else if (level_onehot) begin
              cand  <= keys_level;
              state <= HELD;
            end else begin
              chord_error <= 1'b1;
              state       <= RELEASE;
            end
          end
        end
        HELD: begin
          if (!enable) begin
            state <= RELEASE;
          end else if ((keys_level & ~cand) != 4'b0000) begin
            chord_error <= 1'b1;
            state       <= RELEASE;
          end else if (keys_level == 4'b0000) begin
            state <= IDLE;
            if (slot_free) begin
              note_out   <= cand;
              note_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        RELEASE: begin
          if (keys_level == 4'b0000)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
